// File: rtl/pwm_pkg.sv
// Shared types, default parameters and helpers for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_PRESCALE_W = 8;

  // A single channel still needs a one-bit select port.
  function automatic int calc_ch_w(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Timebase prescaler: emits one tick every (divide+1) clocks; the divide value
// is reloaded from its shadow only when the top asks for it (period boundary / idle).
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run_i,
  input  logic                  load_i,
  input  logic [PRESCALE_W-1:0] prescale_shd_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [PRESCALE_W-1:0] act_q, act_d;

  assign tick_o = run_i && (div_q == act_q);

  always_comb begin
    div_d = div_q + 1'b1;
    act_d = act_q;
    if (!run_i || tick_o) begin
      div_d = '0;
    end
    if (load_i) begin
      act_d = prescale_shd_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
      act_q <= '0;
    end else begin
      div_q <= div_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with a shared prescaled timebase and shadow/active registers
// that swap at period boundaries. Define PWM_CENTER_ALIGN_EN for up/down counting.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int CH_W       = calc_ch_w(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  center_mode,
  input  logic [WIDTH-1:0]      period,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  wr_valid,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [WIDTH-1:0]      wr_duty,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_start
);

  logic                  tick;
  logic                  boundary;
  logic                  load_act;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      period_shd_q, period_act_q;
  logic [PRESCALE_W-1:0] prescale_shd_q;
  logic                  new_period_q;
  logic                  period_start_q;

  // While idle the active set follows the shadows, so a restart uses fresh values.
  assign load_act = boundary || !enable;

  pwm_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk           (clk),
    .reset_n       (reset_n),
    .run_i         (enable),
    .load_i        (load_act),
    .prescale_shd_i(prescale_shd_q),
    .tick_o        (tick)
  );

`ifdef PWM_CENTER_ALIGN_EN
  pwm_mode_e mode_shd_q, mode_act_q;
  logic      dir_down_q, dir_down_d;
`else
  logic unused_center;
  assign unused_center = center_mode;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_down_d = dir_down_q;
`endif
    if (!enable) begin
      cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_down_d = 1'b0;
`endif
    end else if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
      if (mode_act_q == PWM_CENTER) begin
        // Landing on 0 while descending closes the period and turns back up.
        if (period_act_q == '0) begin
          boundary = 1'b1;
        end else if (dir_down_q || (cnt_q == period_act_q)) begin
          cnt_d      = cnt_q - 1'b1;
          boundary   = (cnt_q == WIDTH'(1));
          dir_down_d = !boundary;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else
`endif
      if (cnt_q == period_act_q) begin
        cnt_d    = '0;
        boundary = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      period_shd_q   <= '0;
      period_act_q   <= '0;
      prescale_shd_q <= '0;
      new_period_q   <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_shd_q   <= period;
      prescale_shd_q <= prescale;
      if (load_act) begin
        period_act_q <= period_shd_q;
      end
      // Delayed one clock so the pulse lines up with the first counter-0 compare.
      new_period_q   <= boundary || !enable;
      period_start_q <= enable && new_period_q;
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_shd_q <= PWM_EDGE;
      mode_act_q <= PWM_EDGE;
      dir_down_q <= 1'b0;
    end else begin
      mode_shd_q <= center_mode ? PWM_CENTER : PWM_EDGE;
      if (load_act) begin
        mode_act_q <= mode_shd_q;
      end
      dir_down_q <= dir_down_d;
    end
  end
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] duty_shd_q, duty_act_q;
    logic             pwm_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        duty_shd_q <= '0;
        duty_act_q <= '0;
        pwm_q      <= 1'b0;
      end else begin
        if (wr_valid && (wr_ch == CH_W'(gi))) begin
          duty_shd_q <= wr_duty;
        end
        if (load_act) begin
          duty_act_q <= duty_shd_q;
        end
        pwm_q <= enable && (cnt_q < duty_act_q);
      end
    end

    assign pwm_out[gi] = pwm_q;
  end

  assign period_start = period_start_q;

endmodule
